// File: rtl/k_phase_pkg.sv
// -----------------------------------------------------------------------------
// k_phase_pkg
//   Shared helpers for the pipelined k-phase rotator.
//   - phase_sum     : pre-direction phase (optionally accumulated), wrapped to
//                     the word length. This is the value the accumulator keeps.
//   - phase_resolve : phase_sum with the rotate direction applied. The result
//                     is a right-rotate amount.
//   - layer_first / layer_last : barrel-layer range owned by a pipeline stage.
//                     Layers are spread evenly, and any remainder goes to the
//                     earliest stages.
//   The phase helpers work on 32-bit values and take the word-length log2 as an
//   argument, so any legal BITSTREAM can share them.
// -----------------------------------------------------------------------------
package k_phase_pkg;

   localparam int DEF_BITSTREAM = 64;
   localparam int LOG2_BS       = $clog2(DEF_BITSTREAM);

   function automatic logic [31:0] phase_sum(input logic [31:0] k,
                                             input logic [31:0] acc,
                                             input logic        acc_en,
                                             input int          log2_bs);
      logic [31:0] mask;
      mask = (32'd1 << log2_bs) - 32'd1;
      if (acc_en) return (acc + k) & mask;
      else        return k & mask;
   endfunction

   function automatic logic [31:0] phase_resolve(input logic [31:0] k,
                                                 input logic [31:0] acc,
                                                 input logic        dir,
                                                 input logic        acc_en,
                                                 input int          log2_bs);
      logic [31:0] mask;
      logic [31:0] e;
      mask = (32'd1 << log2_bs) - 32'd1;
      e    = phase_sum(k, acc, acc_en, log2_bs);
      // A left rotate by e is a right rotate by (N - e) mod N.
      if (dir) return (32'd0 - e) & mask;
      else     return e;
   endfunction

   function automatic int layer_first(input int stage, input int n_layers,
                                      input int n_stages);
      int base;
      int rem;
      base = n_layers / n_stages;
      rem  = n_layers % n_stages;
      return stage * base + ((stage < rem) ? stage : rem);
   endfunction

   function automatic int layer_last(input int stage, input int n_layers,
                                     input int n_stages);
      return layer_first(stage + 1, n_layers, n_stages) - 1;
   endfunction

endpackage

// File: rtl/k_phase_rot_pipe_layers.sv
// -----------------------------------------------------------------------------
// k_rot_layers
//   Combinational right-rotate of one word through barrel layers LO..HI.
//   Layer j rotates the word by 2^j when bit j of the rotate amount is set.
//   Ports:
//     d_i  : input word
//     sh_i : rotate-amount bits HI..LO (sh_i[0] is layer LO)
//     q_o  : rotated word
// -----------------------------------------------------------------------------
module k_rot_layers #(
   parameter int W  = 64,
   parameter int LO = 0,
   parameter int HI = 0
) (
   input  logic [W-1:0]     d_i,
   input  logic [HI-LO:0]   sh_i,
   output logic [W-1:0]     q_o
);

   logic [W-1:0] v;

   always_comb begin
      v = d_i;
      for (int j = LO; j <= HI; j++) begin
         if (sh_i[j-LO]) v = (v >> (1 << j)) | (v << (W - (1 << j)));
      end
   end

   assign q_o = v;

endmodule

// File: rtl/k_phase_rot_pipe.sv
// -----------------------------------------------------------------------------
// k_phase_rot_pipe
//   Multi-channel pipelined phase rotator for stochastic bitstreams. It rotates
//   each channel word by its own phase k, either right or left. The phase can
//   optionally be added to a per-channel accumulator. The rotator sits between
//   the bitstream generators and the stochastic arithmetic array.
//
//   Ports:
//     clk, rst_n   : clock; asynchronous active-low reset
//     in_valid     : input transaction valid
//     in_ready     : input transaction accepted this cycle
//     in_bits      : CHANNELS packed words, channel c at [c*BITSTREAM +: BITSTREAM]
//     k            : per-channel phase, packed the same way (K_WIDTH each)
//     dir          : 0 = rotate right, 1 = rotate left (all channels)
//     acc_en       : rotate by accumulator + k and store the new sum
//     acc_clr      : clear all accumulators at the next edge
//     out_valid    : output transaction valid
//     out_ready    : downstream accepts
//     out_bits     : rotated words
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. A valid is never withdrawn while its ready is 0. in_ready is derived
//   only from out_ready and the stage valids, never from in_valid. out_bits
//   holds steady while out_valid=1 and out_ready=0.
//
//   Stage 0 registers the resolved rotate amount with the data. Each stage
//   applies its slice of the barrel layers in front of its register. A stage
//   loads when it is empty or when its successor loads, so bubbles collapse.
// -----------------------------------------------------------------------------
module k_phase_rot_pipe
   import k_phase_pkg::*;
#(
   parameter int BITSTREAM   = DEF_BITSTREAM,
   parameter int CHANNELS    = 4,
   parameter int K_WIDTH     = $clog2(BITSTREAM),
   parameter int PIPE_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CHANNELS*BITSTREAM-1:0] in_bits,
   input  logic [CHANNELS*K_WIDTH-1:0]   k,
   input  logic                          dir,
   input  logic                          acc_en,
   input  logic                          acc_clr,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CHANNELS*BITSTREAM-1:0] out_bits
);

   localparam int LB = $clog2(BITSTREAM);

   // Phase resolve and accumulators.
   logic [LB-1:0] km    [CHANNELS];
   logic [LB-1:0] e_sum [CHANNELS];
   logic [LB-1:0] e_res [CHANNELS];
   logic [LB-1:0] acc_q [CHANNELS];

   for (genvar c = 0; c < CHANNELS; c++) begin : g_resolve
      // k mod BITSTREAM is simply the low LB bits of the phase field.
      assign km[c]    = k[c*K_WIDTH +: LB];
      assign e_sum[c] = LB'(phase_sum(32'(km[c]), 32'(acc_q[c]), acc_en, LB));
      assign e_res[c] = LB'(phase_resolve(32'(km[c]), 32'(acc_q[c]), dir,
                                          acc_en, LB));
   end

   logic in_hs;
   assign in_hs = in_valid && in_ready;

   // A clear wins over an update. The transaction in a clear cycle still
   // rotates by the old accumulator, because e_res is taken from acc_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      end else if (acc_clr) begin
         for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      end else if (in_hs && acc_en) begin
         for (int c = 0; c < CHANNELS; c++) acc_q[c] <= e_sum[c];
      end
   end

   // Pipeline stages.
   logic [PIPE_STAGES-1:0] vld_q;
   logic [PIPE_STAGES-1:0] vin;
   logic [PIPE_STAGES-1:0] load;
   logic [BITSTREAM-1:0]   dat_q [PIPE_STAGES][CHANNELS];
   logic [BITSTREAM-1:0]   dat_d [PIPE_STAGES][CHANNELS];
   logic [LB-1:0]          er_q  [PIPE_STAGES][CHANNELS];
   logic [LB-1:0]          er_d  [PIPE_STAGES][CHANNELS];

   always_comb begin
      load = '0;
      vin  = '0;
      load[PIPE_STAGES-1] = !vld_q[PIPE_STAGES-1] || out_ready;
      for (int s = PIPE_STAGES - 2; s >= 0; s--) begin
         load[s] = !vld_q[s] || load[s+1];
      end
      vin[0] = in_valid;
      for (int s = 1; s < PIPE_STAGES; s++) vin[s] = vld_q[s-1];
   end

   assign in_ready = load[0];

   for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
      localparam int LO = layer_first(s, LB, PIPE_STAGES);
      localparam int HI = layer_last(s, LB, PIPE_STAGES);
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         logic [BITSTREAM-1:0] src_dat;
         logic [LB-1:0]        src_er;
         if (s == 0) begin : g_head
            assign src_dat = in_bits[c*BITSTREAM +: BITSTREAM];
            assign src_er  = e_res[c];
         end else begin : g_body
            assign src_dat = dat_q[s-1][c];
            assign src_er  = er_q[s-1][c];
         end
         assign er_d[s][c] = src_er;
         k_rot_layers #(
            .W  (BITSTREAM),
            .LO (LO),
            .HI (HI)
         ) u_rot (
            .d_i  (src_dat),
            .sh_i (src_er[HI:LO]),
            .q_o  (dat_d[s][c])
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int s = 0; s < PIPE_STAGES; s++) begin
            for (int c = 0; c < CHANNELS; c++) begin
               dat_q[s][c] <= '0;
               er_q[s][c]  <= '0;
            end
         end
      end else begin
         for (int s = 0; s < PIPE_STAGES; s++) begin
            if (load[s]) begin
               vld_q[s] <= vin[s];
               // Payload is only captured for real transactions. A bubble
               // leaves the old contents in place.
               if (vin[s]) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     dat_q[s][c] <= dat_d[s][c];
                     er_q[s][c]  <= er_d[s][c];
                  end
               end
            end
         end
      end
   end

   assign out_valid = vld_q[PIPE_STAGES-1];

   for (genvar c = 0; c < CHANNELS; c++) begin : g_out
      assign out_bits[c*BITSTREAM +: BITSTREAM] = dat_q[PIPE_STAGES-1][c];
   end

endmodule

// File: tb/tb_k_phase_rot_pipe.sv
module tb_k_phase_rot_pipe;

   localparam int W  = 64;
   localparam int CH = 4;
   localparam int KW = 6;
   localparam int S  = 2;
   localparam int BW = CH * W;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [BW-1:0]   in_bits;
   logic [CH*KW-1:0] k;
   logic            dir;
   logic            acc_en;
   logic            acc_clr;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [BW-1:0]   out_bits;

   k_phase_rot_pipe #(
      .BITSTREAM   (W),
      .CHANNELS    (CH),
      .K_WIDTH     (KW),
      .PIPE_STAGES (S)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bits   (in_bits),
      .k         (k),
      .dir       (dir),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits)
   );

   // clock
   always #5 clk = ~clk;

   // scoreboard state
   logic [BW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
   int macc[CH];       // model accumulators

   task automatic check(input string name, input logic ok,
                        input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [BW-1:0] put(input int c, input logic [W-1:0] w);
      logic [BW-1:0] r;
      r = '0;
      r[c*W +: W] = w;
      return r;
   endfunction

   function automatic logic [CH*KW-1:0] kput(input int c, input int v);
      logic [CH*KW-1:0] r;
      logic [KW-1:0] kv;
      r  = '0;
      kv = KW'(v);
      r[c*KW +: KW] = kv;
      return r;
   endfunction

   // Reference rotate: out bit i takes input bit (i + e) mod W.
   function automatic logic [W-1:0] rot_ref(input logic [W-1:0] w, input int e);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = w[(i + e) % W];
      return r;
   endfunction

   function automatic int model_e(input int c, input logic [CH*KW-1:0] kk,
                                  input logic ae);
      int km;
      km = int'(kk[c*KW +: KW]) % W;
      return ae ? (macc[c] + km) % W : km;
   endfunction

   function automatic logic [BW-1:0] model_out(input logic [BW-1:0] bits,
                                               input logic [CH*KW-1:0] kk,
                                               input logic d, input logic ae);
      logic [BW-1:0] r;
      int e;
      int er;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         e  = model_e(c, kk, ae);
         er = d ? (W - e) % W : e;
         r[c*W +: W] = rot_ref(bits[c*W +: W], er);
      end
      return r;
   endfunction

   // Driver: one transaction, held until accepted. The model accumulators
   // advance once per edge in which the DUT sees the inputs.
   task automatic send(input logic [BW-1:0] bits, input logic [CH*KW-1:0] kk,
                       input logic d, input logic ae, input logic ac,
                       input logic use_hand, input logic [BW-1:0] hand);
      logic hs;
      logic done;
      int   e_new[CH];
      done = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_bits  = bits;
      k        = kk;
      dir      = d;
      acc_en   = ae;
      acc_clr  = ac;
      for (int t = 0; t < 200 && !done; t++) begin
         #2;
         hs = in_ready;
         if (hs) exp_q.push_back(use_hand ? hand : model_out(bits, kk, d, ae));
         for (int c = 0; c < CH; c++) e_new[c] = model_e(c, kk, ae);
         for (int c = 0; c < CH; c++) begin
            if (ac) macc[c] = 0;
            else if (hs && ae) macc[c] = e_new[c];
         end
         @(posedge clk);
         if (hs) done = 1'b1;
         else @(negedge clk);
      end
      if (!done) check("handshake_timeout", 1'b0, '0, 1);
      #1;
      in_valid = 1'b0;
      acc_clr  = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("drain_empty", exp_q.size() == 0, BW'(exp_q.size()), '0);
   endtask

   // Monitor: drives out_ready, pops and compares on each output transfer, and
   // checks that a stalled output holds.
   initial begin
      logic          held;
      logic [BW-1:0] held_bits;
      logic [BW-1:0] e;
      held = 1'b0;
      held_bits = '0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #2;
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_valid", out_valid == 1'b1, BW'(out_valid), 1);
               check("hold_bits", out_bits == held_bits, out_bits, held_bits);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 1'b0, out_bits, '0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_bits", out_bits == e, out_bits, e);
               end
               held = 1'b0;
            end else if (out_valid) begin
               held      = 1'b1;
               held_bits = out_bits;
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   // Main stimulus.
   initial begin
      int cnt;
      logic [BW-1:0] rb;
      logic [CH*KW-1:0] rk;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_bits  = '0;
      k        = '0;
      dir      = 1'b0;
      acc_en   = 1'b0;
      acc_clr  = 1'b0;
      for (int c = 0; c < CH; c++) macc[c] = 0;

      repeat (3) @(negedge clk);
      check("reset_out_valid", out_valid == 1'b0, BW'(out_valid), 0);
      check("reset_out_bits", out_bits == '0, out_bits, '0);
      #3 rst_n = 1'b1;
      #1 check("reset_in_ready", in_ready == 1'b1, BW'(in_ready), 1);

      // Basic rotate right by 1, plus the first-transaction latency.
      send(put(0, 64'h1), kput(0, 1), 1'b0, 1'b0, 1'b0,
           1'b1, put(0, 64'h8000_0000_0000_0000));
      cnt = 0;
      while (!out_valid && cnt < 10) begin
         @(posedge clk);
         #1 cnt++;
      end
      check("latency_edges", cnt == S - 1, BW'(cnt), BW'(S - 1));

      // Left rotate and zero phases.
      send(put(1, 64'hF), kput(1, 4), 1'b1, 1'b0, 1'b0,
           1'b1, put(1, 64'hF0));
      send(put(3, 64'hDEAD_BEEF_0123_4567), kput(3, 0), 1'b0, 1'b0, 1'b0,
           1'b1, put(3, 64'hDEAD_BEEF_0123_4567));
      send(put(3, 64'hDEAD_BEEF_0123_4567), kput(3, 0), 1'b1, 1'b0, 1'b0,
           1'b1, put(3, 64'hDEAD_BEEF_0123_4567));
      send(put(0, 64'hFF), kput(0, 8), 1'b0, 1'b0, 1'b0,
           1'b1, put(0, 64'hFF00_0000_0000_0000));

      // Accumulated phase on ch2: 40, 80 mod 64 = 16, 56; then clear with k=3.
      send(put(2, 64'h1), kput(2, 40), 1'b0, 1'b1, 1'b0,
           1'b1, put(2, 64'h0000_0000_0100_0000));
      send(put(2, 64'h1), kput(2, 40), 1'b0, 1'b1, 1'b0,
           1'b1, put(2, 64'h0001_0000_0000_0000));
      send(put(2, 64'h1), kput(2, 40), 1'b0, 1'b1, 1'b0,
           1'b1, put(2, 64'h0000_0000_0000_0100));
      send(put(2, 64'h1), kput(2, 3), 1'b0, 1'b1, 1'b1,
           1'b1, put(2, 64'h0000_0000_0000_0020));
      send(put(2, 64'h1), kput(2, 3), 1'b0, 1'b1, 1'b0,
           1'b1, put(2, 64'h2000_0000_0000_0000));
      drain();

      // Backpressure: the accumulator may only step on accepted transfers.
      rdy_mode = 1;
      fork
         begin
            send(put(0, 64'h1), kput(0, 1), 1'b0, 1'b1, 1'b0,
                 1'b1, put(0, 64'h8000_0000_0000_0000));
            send(put(0, 64'h1), kput(0, 1), 1'b0, 1'b1, 1'b0,
                 1'b1, put(0, 64'h4000_0000_0000_0000));
            send(put(0, 64'h1), kput(0, 1), 1'b0, 1'b1, 1'b0,
                 1'b1, put(0, 64'h2000_0000_0000_0000));
            send(put(0, 64'h1), kput(0, 1), 1'b0, 1'b1, 1'b0,
                 1'b1, put(0, 64'h1000_0000_0000_0000));
         end
         begin
            repeat (5) @(negedge clk);
            #3;
            check("bp_in_ready_low", in_ready == 1'b0, BW'(in_ready), 0);
            check("bp_out_valid", out_valid == 1'b1, BW'(out_valid), 1);
            rdy_mode = 0;
         end
      join
      drain();

      // Random traffic against the model.
      rdy_mode = 2;
      for (int n = 0; n < 1000; n++) begin
         rb = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
         for (int c = 0; c < CH; c++) rk[c*KW +: KW] = KW'($urandom_range(0, 63));
         send(rb, rk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 19) == 0), 1'b0, '0);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      rdy_mode = 0;
      drain();

      // Reset with a full, stalled pipeline.
      rdy_mode = 1;
      send(put(1, 64'h3), kput(1, 7), 1'b0, 1'b1, 1'b0, 1'b0, '0);
      send(put(1, 64'h3), kput(1, 9), 1'b1, 1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", out_valid == 1'b0, BW'(out_valid), 0);
      check("rst_mid_out_bits", out_bits == '0, out_bits, '0);
      exp_q.delete();
      for (int c = 0; c < CH; c++) macc[c] = 0;
      rdy_mode = 0;
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b1;
      #1 check("rst_mid_in_ready", in_ready == 1'b1, BW'(in_ready), 1);
      send(put(3, 64'h1), kput(3, 5), 1'b0, 1'b1, 1'b0,
           1'b1, put(3, 64'h0800_0000_0000_0000));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/k_phase_rot_pipe.md
Name: k_phase_rot_pipe

Overview:
- Pipelined, multi-channel successor to the 2-bit combinational phase rotator for stochastic bitstreams.
- Per channel, rotates a BITSTREAM-bit word by a full-range phase k. Supports right or left rotation and an optional per-channel accumulated phase.
- Sits between the Weyl/SNG bitstream generators and the stochastic arithmetic array to decorrelate streams.
- Uses valid/ready streaming with backpressure and a fixed latency of PIPE_STAGES cycles.

Parameters:
- BITSTREAM, 64, word length per channel; must be a power of two, at least 4.
- CHANNELS, 4, number of independent channels per transaction.
- K_WIDTH, $clog2(BITSTREAM), phase field width per channel; must be at least $clog2(BITSTREAM).
- PIPE_STAGES, 2, register stages; range 1..$clog2(BITSTREAM).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept a transaction.
- in_bits  in  CHANNELS*BITSTREAM  packed input words; channel c is at [c*BITSTREAM +: BITSTREAM].
- k  in  CHANNELS*K_WIDTH  per-channel phase, packed the same way.
- dir  in  1  0 = rotate right, 1 = rotate left; applies to all channels of the transaction.
- acc_en  in  1  1 = add k to the channel accumulator and rotate by the sum.
- acc_clr  in  1  synchronous clear of all accumulators.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts.
- out_bits  out  CHANNELS*BITSTREAM  rotated words.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_bits=0, all stage valids=0, all accumulators=0.
  - in_ready=1 once reset is released.
- Effective phase:
  - km = k[c] mod BITSTREAM, i.e. the low $clog2(BITSTREAM) bits.
  - acc_en=1: e = (acc[c] + km) mod BITSTREAM.
  - acc_en=0: e = km.
  - dir=1: e_r = (BITSTREAM - e) mod BITSTREAM. dir=0: e_r = e.
  - Result: out = (in >> e_r) | (in << (BITSTREAM - e_r)); e_r=0 passes the word unchanged.
- Accumulator update:
  - Only on input handshake (in_valid & in_ready) with acc_en=1: acc[c] <= e, using the same wrap.
  - acc_clr=1: accumulators go to 0 at the next edge and have priority over any update.
  - If acc_clr and a handshake with acc_en occur in the same cycle:
    - the transaction rotates by acc_old + km;
    - the accumulator ends at 0.
  - dir does not affect acc; it stores the pre-direction phase.
- Pipeline:
  - Phase-resolve plus $clog2(BITSTREAM) barrel layers (layer j shifts by 2^j when e_r bit j is set).
  - Layers are split across PIPE_STAGES registers, with ceil distribution to the earliest stages.
  - Stage 0 registers the resolved e_r per channel together with in_bits.
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES-1 when no stalls occur. Throughput is 1 per cycle.
- Flow control:
  - Stage i loads when its valid=0 or stage i+1 loads; the last stage loads when out_valid=0 or out_ready=1.
  - in_ready = stage-0 load condition. Bubbles collapse.
  - While out_valid=1 and out_ready=0, out_bits stays stable.
  - in_ready is combinational from out_ready through stage valids; it never depends on in_valid.
- Ordering is strictly FIFO. There is no drop or reorder.
- Reset mid-operation: all in-flight transactions are discarded and accumulators cleared.
- Full pipeline with out_ready=0: in_ready=0 and no accumulator update occurs (no handshake).

Decomposition:
- Package k_phase_pkg:
  - function phase_resolve(k, acc, dir, acc_en);
  - localparam LOG2_BS;
  - function layer_first(stage) and layer_last(stage) for the layer split.
- Sub-module k_rot_layers:
  - combinational right-rotate of one word across layers [lo:hi];
  - instantiated CHANNELS×PIPE_STAGES times.

Test Plan:
- Reset, then in_bits ch0=64'h0000_0000_0000_0001, k=1, dir=0, acc_en=0 -> ch0 out = 64'h8000_0000_0000_0000, out_valid after PIPE_STAGES-1 edges.
- dir=1, k=4, ch1 in=64'h0000_0000_0000_000F -> 64'h0000_0000_0000_00F0. Also k=64 or k=0 -> word unchanged.
- acc_en=1 stream on ch2 with k=40, 40, 40 -> rotations 40, 16 (80 mod 64), 56. Then acc_clr with k=3 -> rotation by 59, and the next transaction with acc_en=1, k=3 -> rotation 3.
- Backpressure:
  - out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 once PIPE_STAGES are held, out_bits stable.
  - Release -> every transaction is delivered in order, none lost or duplicated.
  - Accumulator advanced only on handshakes.
- Random: 1000 transactions with random k/dir/acc_en and random out_ready (50%) -> matches a scoreboard of the reference rotate with a modeled accumulator.
- rst_n asserted with the pipeline full -> out_valid=0 immediately; after release the first output reflects only post-reset inputs with acc=0.
